// File: rtl/p_stream_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// p_stream_ctrl_pkg : shared FSM states, frame geometry and byte helper
// Revision 1.0
// ---------------------------------------------------------------------------
package p_stream_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_KEY = 3'd1,
    ST_LOAD_PT  = 3'd2,
    ST_LAUNCH   = 3'd3,
    ST_RUN      = 3'd4,
    ST_DRAIN    = 3'd5
  } state_t;

  localparam int KEY_BYTES      = 10;
  localparam int BLK_BYTES      = 8;
  localparam int HDR_NEWKEY_BIT = 0;

  // Byte 0 is the most significant byte of the block.
  function automatic logic [7:0] blk_byte(input logic [63:0] v, input logic [2:0] idx);
    return v[8*(7-int'(idx)) +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/p_stream_ser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// p_stream_ser : 64-bit parallel-load to byte serializer with valid/ready
// Revision 1.0
// ---------------------------------------------------------------------------
module p_stream_ser
  import p_stream_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [63:0] i_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [7:0]  o_data,
  output logic        o_done
);

  logic [63:0] r_ct;
  logic [2:0]  r_idx;
  logic        r_valid;
  logic        w_hs;

  assign w_hs    = r_valid && i_ready;
  assign o_valid = r_valid;
  assign o_data  = blk_byte(r_ct, r_idx);
  assign o_done  = w_hs && (r_idx == 3'd7);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ct    <= 64'd0;
      r_idx   <= 3'd0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_ct    <= i_data;
      r_idx   <= 3'd0;
      r_valid <= 1'b1;
    end else if (w_hs) begin
      r_idx <= r_idx + 3'd1;
      if (r_idx == 3'd7) r_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/p_stream_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// p_stream_ctrl : byte-serial key/plaintext loader and start/end sequencer
//                 for the p block cipher core, with ciphertext byte drain
// Revision 1.0
// ---------------------------------------------------------------------------
module p_stream_ctrl
  import p_stream_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        busy,
  output logic        err,
  output logic [63:0] core_state,
  output logic [79:0] core_keys,
  output logic        core_start,
  input  logic        core_end,
  input  logic [63:0] core_result
);

  localparam int            c_TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TW-1:0] c_TMAX = c_TW'(TIMEOUT_CYCLES - 1);

  state_t          r_state;
  state_t          w_next;
  logic [79:0]     r_key;
  logic [63:0]     r_pt;
  logic [3:0]      r_cnt;
  logic [c_TW-1:0] r_timer;
  logic            r_start;
  logic            r_err;
  logic            w_acc;
  logic            w_capture;
  logic            w_ser_done;

  assign w_acc      = in_valid && in_ready;
  assign w_capture  = (r_state == ST_RUN) && core_end;
  assign core_state = r_pt;
  assign core_keys  = r_key;
  assign core_start = r_start;
  assign err        = r_err;

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    busy     = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (w_acc) w_next = in_data[HDR_NEWKEY_BIT] ? ST_LOAD_KEY : ST_LOAD_PT;
      end
      ST_LOAD_KEY: begin
        in_ready = 1'b1;
        if (w_acc && r_cnt == 4'(KEY_BYTES - 1)) w_next = ST_LOAD_PT;
      end
      ST_LOAD_PT: begin
        in_ready = 1'b1;
        if (w_acc && r_cnt == 4'(BLK_BYTES - 1)) w_next = ST_LAUNCH;
      end
      ST_LAUNCH: w_next = ST_RUN;
      ST_RUN: begin
        if (core_end)              w_next = ST_DRAIN;
        else if (r_timer == c_TMAX) w_next = ST_IDLE;
      end
      ST_DRAIN: if (w_ser_done) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_key   <= 80'd0;
      r_pt    <= 64'd0;
      r_cnt   <= 4'd0;
      r_timer <= '0;
      r_start <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_acc) r_cnt <= 4'd0;
        ST_LOAD_KEY: if (w_acc) begin
          r_key <= {r_key[71:0], in_data};
          r_cnt <= (r_cnt == 4'(KEY_BYTES - 1)) ? 4'd0 : r_cnt + 4'd1;
        end
        ST_LOAD_PT: if (w_acc) begin
          r_pt  <= {r_pt[55:0], in_data};
          r_cnt <= r_cnt + 4'd1;
        end
        // core_start stays low for this one cycle so p reloads its inputs
        ST_LAUNCH: begin
          r_start <= 1'b1;
          r_timer <= '0;
        end
        ST_RUN: begin
          r_timer <= r_timer + 1'b1;
          if (core_end) begin
            r_start <= 1'b0;
          end else if (r_timer == c_TMAX) begin
            r_start <= 1'b0;
            r_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  p_stream_ser u_ser (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .i_load  (w_capture),
    .i_data  (core_result),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (out_data),
    .o_done  (w_ser_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_p_stream_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_p_stream_ctrl : directed bench with a stub p core (xor, fixed latency)
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_p_stream_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        busy;
  logic        err;
  logic [63:0] core_state;
  logic [79:0] core_keys;
  logic        core_start;
  logic        core_end;
  logic [63:0] core_result;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  p_stream_ctrl #(.TIMEOUT_CYCLES(40)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .err        (err),
    .core_state (core_state),
    .core_keys  (core_keys),
    .core_start (core_start),
    .core_end   (core_end),
    .core_result(core_result)
  );

  // Stub core: xor with the top 64 key bits, end after 31 start-high edges
  logic [4:0] stub_cnt = 5'd0;
  logic       stub_en;
  always @(posedge sys_clk) begin
    if (!core_start)            stub_cnt <= 5'd0;
    else if (stub_cnt != 5'd31) stub_cnt <= stub_cnt + 5'd1;
  end
  assign core_end    = stub_en && core_start && (stub_cnt == 5'd31);
  assign core_result = core_state ^ core_keys[79:16];

  typedef struct {
    logic [7:0]  hdr;
    logic [79:0] key;
    logic [63:0] pt;
    logic [63:0] ct;
    bit          stall;
    bit          hold_in;
  } vec_t;

  vec_t        vecs[5];
  logic [79:0] model_key;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 100) begin
      @(posedge sys_clk); #1;
      n++;
    end
    if (!in_ready) check("in_ready_wait", 80'(in_ready), 80'd1);
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input vec_t v, output int e0);
    send_byte(v.hdr);
    if (v.hdr[0]) for (int i = 0; i < 10; i++) send_byte(v.key[79-8*i -: 8]);
    for (int i = 0; i < 8; i++) send_byte(v.pt[63-8*i -: 8]);
    e0 = cyc;
  endtask

  task automatic run_vec(input vec_t v);
    int          e0;
    int          n;
    int          k;
    int          p;
    bit          hs;
    bit          bad_ready;
    logic [63:0] tmp;
    if (v.hdr[0]) model_key = v.key;
    send_frame(v, e0);
    if (v.hold_in) begin
      in_valid = 1'b1;
      in_data  = 8'h55;
    end
    check("launch_start_low", 80'(core_start), 80'd0);
    check("core_keys", core_keys, model_key);
    check("core_state", 80'(core_state), 80'(v.pt));
    n = 0;
    bad_ready = 1'b0;
    while (!out_valid && n < 100) begin
      if (in_ready) bad_ready = 1'b1;
      @(posedge sys_clk); #1;
      n++;
    end
    check("latency", 80'(cyc - e0), 80'd33);
    if (v.hold_in) check("in_ready_held_off", 80'(bad_ready), 80'd0);
    in_valid = 1'b0;
    tmp = v.ct;
    k = 0; n = 0; p = 0;
    while (k < 8 && n < 200) begin
      out_ready = v.stall ? (p % 3 == 0) : 1'b1;
      check("out_valid", 80'(out_valid), 80'd1);
      check("out_data", 80'(out_data), 80'(tmp[63-8*k -: 8]));
      check("busy_drain", 80'(busy), 80'd1);
      hs = out_valid && out_ready;
      @(posedge sys_clk); #1;
      if (hs) k++;
      n++; p++;
    end
    out_ready = 1'b0;
    check("drain_count", 80'(k), 80'd8);
    check("out_valid_end", 80'(out_valid), 80'd0);
    check("busy_end", 80'(busy), 80'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   e0;
    int   j;
    int   nerr;
    int   err_at;
    int   nstart;
    int   nov;
    vec_t tv;

    vecs[0] = '{8'h01, 80'h00010203040506070809, 64'hFFFFFFFFFFFFFFFF, 64'hFFFEFDFCFBFAF9F8, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 80'h0, 64'h0000000000000000, 64'h0001020304050607, 1'b0, 1'b0};
    vecs[2] = '{8'h01, 80'hFFFFFFFFFFFFFFFFFFFF, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b1, 1'b1};
    vecs[3] = '{8'hFE, 80'h0, 64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0};
    vecs[4] = '{8'h03, 80'h123456789ABCDEF01122, 64'h1111111111111111, 64'h032547698BADCFE1, 1'b1, 1'b0};

    sys_rst_n = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    stub_en   = 1'b1;
    model_key = 80'd0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_busy", 80'(busy), 80'd0);
    check("rst_out_valid", 80'(out_valid), 80'd0);
    check("rst_err", 80'(err), 80'd0);
    check("rst_core_start", 80'(core_start), 80'd0);
    check("rst_core_keys", core_keys, 80'd0);
    check("rst_core_state", 80'(core_state), 80'd0);
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    check("idle_in_ready", 80'(in_ready), 80'd1);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Timeout: core never ends
    stub_en = 1'b0;
    tv = '{8'h00, 80'h0, 64'hA5A5A5A5A5A5A5A5, 64'h0, 1'b0, 1'b0};
    send_frame(tv, e0);
    nerr = 0; err_at = -1; nstart = 0; nov = 0;
    j = cyc - e0;
    while (j < 50) begin
      @(posedge sys_clk); #1;
      j = cyc - e0;
      if (err) begin nerr++; err_at = j; end
      if (core_start) nstart++;
      if (out_valid) nov++;
    end
    check("timeout_err_pulses", 80'(nerr), 80'd1);
    check("timeout_err_cycle", 80'(err_at), 80'd41);
    check("timeout_start_cycles", 80'(nstart), 80'd40);
    check("timeout_no_out_valid", 80'(nov), 80'd0);
    check("timeout_idle", 80'(busy), 80'd0);
    stub_en = 1'b1;

    // Reset during RUN drops the stored key
    tv = '{8'h00, 80'h0, 64'h0, 64'h0, 1'b0, 1'b0};
    send_frame(tv, e0);
    repeat (10) @(posedge sys_clk);
    #1;
    check("pre_reset_busy", 80'(busy), 80'd1);
    sys_rst_n = 1'b0;
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    check("mid_rst_busy", 80'(busy), 80'd0);
    check("mid_rst_start", 80'(core_start), 80'd0);
    check("mid_rst_keys", core_keys, 80'd0);
    check("mid_rst_out_valid", 80'(out_valid), 80'd0);
    check("mid_rst_in_ready", 80'(in_ready), 80'd1);
    model_key = 80'd0;
    run_vec(tv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
